// File: rtl/seg_scan_display_ctrl_if.sv
// Bundle of control, value and display signals between the vehicle-state datapath and the
// multiplexed 7-segment driver.
interface seg_scan_display_ctrl_if #(
    parameter int NUM_DIGITS = 8,
    parameter int VAL_W      = 14
);
    logic                  tick_scan;
    logic                  tick_blink;
    // upd is a one-cycle request, taken only while busy=0; a request seen while busy=1 is
    // discarded (there is no backpressure, the requester must watch busy).
    logic                  upd;
    logic [VAL_W-1:0]      val_a;
    logic [VAL_W-1:0]      val_b;
    logic                  hex_mode;
    logic                  lzb_en;
    logic [1:0]            blink_mask;
    logic [2:0]            bright;
    logic [NUM_DIGITS-1:0] dp_mask;
    logic                  busy;
    logic [7:0]            seg_data;
    logic [NUM_DIGITS-1:0] seg_com;
    logic [1:0]            fsm_state;

    modport master (
        output tick_scan, tick_blink, upd, val_a, val_b, hex_mode,
               lzb_en, blink_mask, bright, dp_mask,
        input  busy, seg_data, seg_com, fsm_state
    );

    modport slave (
        input  tick_scan, tick_blink, upd, val_a, val_b, hex_mode,
               lzb_en, blink_mask, bright, dp_mask,
        output busy, seg_data, seg_com, fsm_state
    );
endinterface

// File: rtl/seg_scan_display_ctrl.sv
// N-digit multiplexed 7-segment driver: two fields converted by a sequential double-dabble,
// with leading-zero blanking, overflow dashes, blink, PWM brightness and decimal points.
module seg_scan_display_ctrl #(
    parameter int NUM_DIGITS     = 8,
    parameter int VAL_W          = 14,
    parameter int COM_ACTIVE_LOW = 1
) (
    input logic clk,
    input logic rst,
    seg_scan_display_ctrl_if.slave bus
);
    localparam int FD = NUM_DIGITS / 2;
    localparam int BW = 4 * FD;
    localparam int SW = $clog2(NUM_DIGITS);
    localparam int CW = $clog2(VAL_W + 1);
    localparam logic [NUM_DIGITS-1:0] COM_OFF = {NUM_DIGITS{COM_ACTIVE_LOW != 0}};

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) r = r * 64'd10;
        return r;
    endfunction

    localparam logic [63:0] DEC_LIMIT = pow10(FD);
    localparam logic [63:0] HEX_LIMIT = 64'd1 << BW;

    function automatic logic [BW-1:0] dabble(input logic [BW-1:0] bcd, input logic bit_in);
        logic [BW-1:0] r;
        r = bcd;
        for (int i = 0; i < FD; i++)
            if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
        return {r[BW-2:0], bit_in};
    endfunction

    function automatic logic [BW-1:0] fit(input logic [VAL_W-1:0] v);
        logic [63:0] w;
        w = 64'(v);
        return w[BW-1:0];
    endfunction

    function automatic logic over(input logic [VAL_W-1:0] v, input logic hex);
        logic [63:0] w;
        w = 64'(v);
        return hex ? (w >= HEX_LIMIT) : (w >= DEC_LIMIT);
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: seg7 = 7'h3F; 4'h1: seg7 = 7'h06; 4'h2: seg7 = 7'h5B; 4'h3: seg7 = 7'h4F;
            4'h4: seg7 = 7'h66; 4'h5: seg7 = 7'h6D; 4'h6: seg7 = 7'h7D; 4'h7: seg7 = 7'h07;
            4'h8: seg7 = 7'h7F; 4'h9: seg7 = 7'h6F; 4'hA: seg7 = 7'h77; 4'hB: seg7 = 7'h7C;
            4'hC: seg7 = 7'h39; 4'hD: seg7 = 7'h5E; 4'hE: seg7 = 7'h79; default: seg7 = 7'h71;
        endcase
    endfunction

    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, COMMIT = 2'd2} state_t;
    state_t state, state_next;

    logic [CW-1:0]    cnt;
    logic [VAL_W-1:0] bin_a, bin_b, raw_a, raw_b;
    logic [BW-1:0]    bcd_a, bcd_b, bcd_a_next, bcd_b_next;
    logic             hex_q;
    logic [BW-1:0]    disp_a, disp_b;
    logic             ovf_a, ovf_b;
    logic [SW-1:0]    scan_idx;
    logic [2:0]       pwm_cnt;
    logic             blink_phase;
    logic [7:0]       seg_q, seg_next;
    logic [NUM_DIGITS-1:0] com_q, com_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.upd) state_next = SHIFT;
            SHIFT:   if (cnt == CW'(VAL_W - 1)) state_next = COMMIT;
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bcd_a_next = dabble(bcd_a, bin_a[VAL_W-1]);
        bcd_b_next = dabble(bcd_b, bin_b[VAL_W-1]);
    end

    // The display registers load on the last shift, so the output stage can
    // register the new digits during COMMIT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0; bin_a <= '0; bin_b <= '0; raw_a <= '0; raw_b <= '0;
            bcd_a <= '0; bcd_b <= '0; hex_q <= 1'b0;
            disp_a <= '0; disp_b <= '0; ovf_a <= 1'b0; ovf_b <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.upd) begin
                    bin_a <= bus.val_a; bin_b <= bus.val_b;
                    raw_a <= bus.val_a; raw_b <= bus.val_b;
                    hex_q <= bus.hex_mode;
                    bcd_a <= '0; bcd_b <= '0; cnt <= '0;
                end
                SHIFT: begin
                    bin_a <= bin_a << 1; bin_b <= bin_b << 1;
                    bcd_a <= bcd_a_next; bcd_b <= bcd_b_next;
                    cnt   <= cnt + 1'b1;
                    if (state_next == COMMIT) begin
                        disp_a <= hex_q ? fit(raw_a) : bcd_a_next;
                        disp_b <= hex_q ? fit(raw_b) : bcd_b_next;
                        ovf_a  <= over(raw_a, hex_q);
                        ovf_b  <= over(raw_b, hex_q);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scan_idx <= '0; pwm_cnt <= 3'd0; blink_phase <= 1'b0;
        end else begin
            if (bus.tick_scan)
                scan_idx <= (scan_idx == SW'(NUM_DIGITS - 1)) ? '0 : scan_idx + 1'b1;
            pwm_cnt     <= pwm_cnt + 3'd1;
            blink_phase <= blink_phase ^ bus.tick_blink;
        end
    end

    logic            is_a, ovf, blank, upper_nz;
    logic [BW-1:0]   field;
    logic [7:0]      glyph;
    logic [NUM_DIGITS-1:0] sel;
    int              pos;

    always_comb begin
        is_a     = int'(scan_idx) >= FD;
        pos      = is_a ? int'(scan_idx) - FD : int'(scan_idx);
        field    = is_a ? disp_a : disp_b;
        ovf      = is_a ? ovf_a : ovf_b;
        upper_nz = 1'b0;
        for (int j = 0; j < FD; j++)
            if (j >= pos && field[4*j +: 4] != 4'd0) upper_nz = 1'b1;
        blank = (blink_phase && (is_a ? bus.blink_mask[1] : bus.blink_mask[0])) ||
                (bus.lzb_en && !ovf && pos != 0 && !upper_nz);
        glyph = ovf ? 8'h40 : {1'b0, seg7(field[pos*4 +: 4])};
        sel   = '0;
        sel[scan_idx] = 1'b1;
        seg_next = 8'h00;
        com_next = COM_OFF;
        if (pwm_cnt <= bus.bright) begin
            com_next = (COM_ACTIVE_LOW != 0) ? ~sel : sel;
            if (!blank) seg_next = glyph | {bus.dp_mask[scan_idx], 7'b0};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seg_q <= 8'h00;
            com_q <= COM_OFF;
        end else begin
            seg_q <= seg_next;
            com_q <= com_next;
        end
    end

    assign bus.busy      = (state != IDLE);
    assign bus.seg_data  = seg_q;
    assign bus.seg_com   = com_q;
    assign bus.fsm_state = state;
endmodule

// File: tb/tb_seg_scan_display_ctrl.sv
// Directed and randomized bench for seg_scan_display_ctrl against an arithmetic digit model.
module tb_seg_scan_display_ctrl;
    localparam int N  = 8;
    localparam int VW = 14;
    localparam int FD = N / 2;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    seg_scan_display_ctrl_if #(.NUM_DIGITS(N), .VAL_W(VW)) bus ();

    seg_scan_display_ctrl #(.NUM_DIGITS(N), .VAL_W(VW), .COM_ACTIVE_LOW(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // reference model state
    logic [VW-1:0] m_a, m_b;
    logic          m_hex;
    logic          m_phase;
    int            cur_idx;
    logic [7:0]    glyph_tab [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                      8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
    logic [7:0]    exp_q [$];

    function automatic logic [7:0] model_seg(input int d);
        longint v, base, p, lim;
        int     pos;
        bit     is_a, ovf, blank;
        logic [7:0] g;
        is_a = d >= FD;
        pos  = is_a ? d - FD : d;
        v    = is_a ? longint'(m_a) : longint'(m_b);
        base = m_hex ? 16 : 10;
        p = 1;
        for (int i = 0; i < pos; i++) p = p * base;
        lim = 1;
        for (int i = 0; i < FD; i++) lim = lim * base;
        ovf   = v >= lim;
        g     = ovf ? 8'h40 : glyph_tab[int'((v / p) % base)];
        blank = (m_phase && (is_a ? bus.blink_mask[1] : bus.blink_mask[0])) ||
                (bus.lzb_en && !ovf && pos > 0 && v < p);
        return blank ? 8'h00 : (g | {bus.dp_mask[d], 7'b0});
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic pulse_scan();
        bus.tick_scan = 1'b1;
        @(negedge clk);
        bus.tick_scan = 1'b0;
        cur_idx = (cur_idx + 1) % N;
    endtask

    task automatic pulse_blink();
        bus.tick_blink = 1'b1;
        @(negedge clk);
        bus.tick_blink = 1'b0;
        m_phase = ~m_phase;
    endtask

    task automatic goto_digit(input int d);
        for (int k = 0; k < N && cur_idx != d; k++) pulse_scan();
    endtask

    task automatic push_model();
        for (int d = 0; d < N; d++) exp_q.push_back(model_seg(d));
    endtask

    task automatic drain_scan(input string tag);
        logic [7:0] e;
        logic [N-1:0] com_exp;
        for (int d = 0; d < N; d++) begin
            goto_digit(d);
            @(negedge clk);
            e = exp_q.pop_front();
            com_exp = ~(N'(1) << d);
            chk($sformatf("%s_seg_d%0d", tag, d), 32'(bus.seg_data), 32'(e));
            chk($sformatf("%s_com_d%0d", tag, d), 32'(bus.seg_com), 32'(com_exp));
        end
    endtask

    task automatic convert(input logic [VW-1:0] a, input logic [VW-1:0] b,
                           input logic hx, input bit drop);
        int n;
        bus.val_a = a; bus.val_b = b; bus.hex_mode = hx; bus.upd = 1'b1;
        @(negedge clk);
        bus.upd = 1'b0;
        m_a = a; m_b = b; m_hex = hx;
        n = 0;
        for (int c = 1; c <= 40; c++) begin
            if (!bus.busy) break;
            n++;
            if (drop && c == 5) begin
                bus.upd = 1'b1; bus.val_a = 14'd9999;
            end else bus.upd = 1'b0;
            @(negedge clk);
        end
        bus.upd = 1'b0;
        chk("busy_cycles", 32'(n), 32'(VW + 1));
    endtask

    task automatic count_lit(input string tag, input logic [2:0] br);
        int lit;
        bus.bright = br;
        @(negedge clk); @(negedge clk);
        lit = 0;
        for (int k = 0; k < 8; k++) begin
            if (bus.seg_com != {N{1'b1}}) lit++;
            @(negedge clk);
        end
        chk(tag, 32'(lit), 32'(br) + 32'd1);
    endtask

    // stimulus and scoreboard
    initial begin
        rst = 1'b0;
        bus.tick_scan = 1'b0; bus.tick_blink = 1'b0; bus.upd = 1'b0;
        bus.val_a = '0; bus.val_b = '0; bus.hex_mode = 1'b0;
        bus.lzb_en = 1'b0; bus.blink_mask = 2'b00; bus.bright = 3'd0; bus.dp_mask = '0;
        m_a = '0; m_b = '0; m_hex = 1'b0; m_phase = 1'b0; cur_idx = 0;

        repeat (3) @(negedge clk);
        chk("rst_com", 32'(bus.seg_com), 32'hFF);
        chk("rst_seg", 32'(bus.seg_data), 32'h00);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        rst = 1'b1;
        bus.bright = 3'd7; bus.lzb_en = 1'b1;
        @(negedge clk);
        for (int d = 0; d < N; d++) exp_q.push_back((d == 0 || d == FD) ? 8'h3F : 8'h00);
        drain_scan("after_rst");

        convert(14'd1234, 14'd56, 1'b0, 1'b0);
        begin
            logic [7:0] tab [8];
            tab = '{8'h7D, 8'h6D, 8'h00, 8'h00, 8'h66, 8'h4F, 8'h5B, 8'h06};
            for (int d = 0; d < N; d++) exp_q.push_back(tab[d]);
        end
        drain_scan("dec_1234_56");

        convert(14'd4321, 14'd7, 1'b0, 1'b1);
        push_model();
        drain_scan("dropped_upd");
        chk("dropped_d7", 32'(model_seg(7)), 32'h66);

        convert(14'd10000, 14'd9999, 1'b0, 1'b0);
        push_model();
        drain_scan("dec_ovf");
        convert(14'h3FFF, 14'h00A, 1'b1, 1'b0);
        push_model();
        drain_scan("hex");

        convert(14'd1234, 14'd56, 1'b0, 1'b0);
        bus.blink_mask = 2'b10;
        pulse_blink();
        push_model();
        drain_scan("blink_a");
        pulse_blink();
        bus.blink_mask = 2'b00;

        count_lit("pwm_b3", 3'd3);
        count_lit("pwm_b0", 3'd0);
        bus.bright = 3'd7;

        bus.dp_mask = 8'h01;
        push_model();
        drain_scan("dp0");
        bus.dp_mask = 8'h00;

        bus.val_a = 14'd777; bus.val_b = 14'd1; bus.hex_mode = 1'b0; bus.upd = 1'b1;
        @(negedge clk);
        bus.upd = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_busy", 32'(bus.busy), 32'h0);
        chk("midrst_com", 32'(bus.seg_com), 32'hFF);
        chk("midrst_seg", 32'(bus.seg_data), 32'h00);
        @(negedge clk);
        rst = 1'b1;
        m_a = '0; m_b = '0; m_hex = 1'b0; m_phase = 1'b0; cur_idx = 0;
        @(negedge clk);
        push_model();
        drain_scan("midrst_zero");
        convert(14'd8765, 14'd43, 1'b0, 1'b0);
        push_model();
        drain_scan("post_rst");

        for (int r = 0; r < 8; r++) begin
            bus.lzb_en     = 1'($urandom_range(0, 1));
            bus.dp_mask    = N'($urandom_range(0, 255));
            bus.blink_mask = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) pulse_blink();
            convert(VW'($urandom_range(0, 16383)), VW'($urandom_range(0, 12000)),
                    1'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
            push_model();
            drain_scan($sformatf("rand%0d", r));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
